// File: rtl/cpu_seq_pkg.sv
// ----------------------------------------------------------------------------
// cpu_seq_pkg
// Shared types and constants for the multi-cycle sequencer.
//   state_e   : sequencer state codes (S_IF..S_ERR, 3 bits wide)
//   STATE_W   : width of the state code / debug state port
//   SEL_INST  : mem_sel value for an instruction fetch (addr = pc)
//   SEL_DATA  : mem_sel value for a data access (addr = alu_result)
// ----------------------------------------------------------------------------
package cpu_seq_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_ERR = 3'd5
    } state_e;

    localparam logic SEL_INST = 1'b0;
    localparam logic SEL_DATA = 1'b1;

endpackage

// File: rtl/mem_wait_timer.sv
// ----------------------------------------------------------------------------
// mem_wait_timer
// Counts consecutive cycles spent waiting on the memory port and flags the
// cycle in which the TIMEOUT-th wait cycle occurs. TIMEOUT = 0 disables it.
// Ports:
//   clk      in  clock, rising edge
//   reset    in  asynchronous, active-low reset
//   waiting  in  memory request outstanding and not acknowledged this cycle
//   clear    in  restart the count (ready seen, no request, or state change)
//   expired  out this cycle is the TIMEOUT-th consecutive wait cycle
// ----------------------------------------------------------------------------
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic waiting,
    input  logic clear,
    output logic expired
);

    // The count only needs to reach TIMEOUT-1: the next wait cycle expires.
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic TIMER_ON = (TIMEOUT != 0);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_last;

    assign w_at_last = (r_cnt == LAST);

    // Combinational so the sequencer can leave for S_ERR on this very cycle.
    assign expired = TIMER_ON & waiting & w_at_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (waiting && !w_at_last) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_seq.sv
// ----------------------------------------------------------------------------
// multicycle_seq
// Multi-cycle sequencer: steps each instruction through IF/ID/EX/MEM/WB,
// shares one handshaked memory port between fetch and data access and fires
// the PC/IR/MDR/regfile write enables.
// Optional feature macro: PERF_CNT_EN adds cyc_cnt/inst_cnt counters.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-low reset
//   run        in   allow next fetch (sampled only in S_IF)
//   is_load    in   decode: load  (stable in S_EX/S_MEM)
//   is_store   in   decode: store (stable in S_EX/S_MEM)
//   is_ctrl    in   decode: branch/jump/nop
//   mem_ready  in   memory completes current request this cycle
//   mem_req    out  memory request valid
//   mem_sel    out  0 = fetch, 1 = data
//   mem_we     out  data write
//   ir_we      out  load IR pulse
//   mdr_we     out  load MDR pulse
//   rf_we      out  regfile write pulse
//   pc_we      out  load PC pulse
//   retire     out  instruction completed pulse
//   err        out  sticky memory-timeout flag
//   state      out  current state code
//   cyc_cnt    out  [PERF_CNT_EN] cycles since reset
//   inst_cnt   out  [PERF_CNT_EN] retired instructions since reset
// ----------------------------------------------------------------------------
module multicycle_seq
    import cpu_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               is_load,
    input  logic               is_store,
    input  logic               is_ctrl,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_sel,
    output logic               mem_we,
    output logic               ir_we,
    output logic               mdr_we,
    output logic               rf_we,
    output logic               pc_we,
    output logic               retire,
    output logic               err,
`ifdef PERF_CNT_EN
    output logic [31:0]        cyc_cnt,
    output logic [31:0]        inst_cnt,
`endif
    output logic [STATE_W-1:0] state
);

    state_e r_state;
    state_e w_state_d;
    logic   r_err;

    logic w_req;
    logic w_sel;
    logic w_we;
    logic w_ir_we;
    logic w_mdr_we;
    logic w_rf_we;
    logic w_pc_we;
    logic w_retire;
    logic w_waiting;
    logic w_clear;
    logic w_expired;

    // Wait timer: a request held without ready counts toward the timeout.
    assign w_waiting = w_req & ~mem_ready;
    assign w_clear   = ~w_waiting | (w_state_d != r_state);

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .waiting (w_waiting),
        .clear   (w_clear),
        .expired (w_expired)
    );

    // Next state and output decode. Memory strobes depend only on state
    // (and run in S_IF); the enables are additionally qualified by mem_ready.
    always_comb begin
        w_state_d = r_state;
        w_req     = 1'b0;
        w_sel     = SEL_INST;
        w_we      = 1'b0;
        w_ir_we   = 1'b0;
        w_mdr_we  = 1'b0;
        w_rf_we   = 1'b0;
        w_pc_we   = 1'b0;
        w_retire  = 1'b0;

        case (r_state)
            S_IF: begin
                if (run) begin
                    w_req = 1'b1;
                    w_sel = SEL_INST;
                    if (mem_ready) begin
                        w_ir_we   = 1'b1;
                        w_state_d = S_ID;
                    end else if (w_expired) begin
                        w_state_d = S_ERR;
                    end
                end
            end

            S_ID: begin
                w_state_d = S_EX;
            end

            S_EX: begin
                if (is_load || is_store) begin
                    w_state_d = S_MEM;
                end else if (is_ctrl) begin
                    w_pc_we   = 1'b1;
                    w_retire  = 1'b1;
                    w_state_d = S_IF;
                end else begin
                    w_state_d = S_WB;
                end
            end

            S_MEM: begin
                w_req = 1'b1;
                w_sel = SEL_DATA;
                // Load wins when both decode bits are set.
                w_we  = is_store & ~is_load;
                if (mem_ready) begin
                    if (is_load) begin
                        w_mdr_we  = 1'b1;
                        w_state_d = S_WB;
                    end else begin
                        w_pc_we   = 1'b1;
                        w_retire  = 1'b1;
                        w_state_d = S_IF;
                    end
                end else if (w_expired) begin
                    w_state_d = S_ERR;
                end
            end

            S_WB: begin
                w_rf_we   = 1'b1;
                w_pc_we   = 1'b1;
                w_retire  = 1'b1;
                w_state_d = S_IF;
            end

            S_ERR: begin
                w_state_d = S_ERR;
            end

            default: begin
                // Illegal codes recover to fetch without driving anything.
                w_state_d = S_IF;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IF;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (w_state_d == S_ERR) begin
            r_err <= 1'b1;
        end
    end

    // Reset masks the outputs directly so they drop without waiting for a
    // clock edge (S_IF with run=1 would otherwise keep mem_req high).
    assign mem_req = reset & w_req;
    assign mem_sel = reset & w_sel;
    assign mem_we  = reset & w_we;
    assign ir_we   = reset & w_ir_we;
    assign mdr_we  = reset & w_mdr_we;
    assign rf_we   = reset & w_rf_we;
    assign pc_we   = reset & w_pc_we;
    assign retire  = reset & w_retire;
    assign err     = r_err;
    assign state   = r_state;

`ifdef PERF_CNT_EN
    logic [31:0] r_cyc_cnt;
    logic [31:0] r_inst_cnt;

    // Both counters wrap naturally and stop once the sequencer has failed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cyc_cnt  <= '0;
            r_inst_cnt <= '0;
        end else if (r_state != S_ERR) begin
            r_cyc_cnt <= r_cyc_cnt + 32'd1;
            if (w_retire) begin
                r_inst_cnt <= r_inst_cnt + 32'd1;
            end
        end
    end

    assign cyc_cnt  = r_cyc_cnt;
    assign inst_cnt = r_inst_cnt;
`endif

endmodule

// File: tb/tb_multicycle_seq.sv
// ----------------------------------------------------------------------------
// tb_multicycle_seq
// Randomized program of instructions with random memory wait states; each
// issued instruction pushes its expected profile (cycles, enable pulses,
// data-port cycles) to a queue that a monitor pops on every retire.
// Directed sections cover reset, run=0 idle, reset during S_MEM and timeout.
// ----------------------------------------------------------------------------
module tb_multicycle_seq;

    localparam int unsigned TO     = 4;
    localparam int          N_PROG = 40;

    logic clk;
    logic reset;
    logic run;
    logic is_load;
    logic is_store;
    logic is_ctrl;
    logic mem_ready;
    logic mem_req;
    logic mem_sel;
    logic mem_we;
    logic ir_we;
    logic mdr_we;
    logic rf_we;
    logic pc_we;
    logic retire;
    logic err;
    logic [2:0] state;
`ifdef PERF_CNT_EN
    logic [31:0] cyc_cnt;
    logic [31:0] inst_cnt;
`endif

    multicycle_seq #(
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .is_load   (is_load),
        .is_store  (is_store),
        .is_ctrl   (is_ctrl),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_sel   (mem_sel),
        .mem_we    (mem_we),
        .ir_we     (ir_we),
        .mdr_we    (mdr_we),
        .rf_we     (rf_we),
        .pc_we     (pc_we),
        .retire    (retire),
        .err       (err),
`ifdef PERF_CNT_EN
        .cyc_cnt   (cyc_cnt),
        .inst_cnt  (inst_cnt),
`endif
        .state     (state)
    );

    // kind: 0 ALU, 1 load, 2 store, 3 ctrl, 4 load+store (behaves as load)
    typedef struct {
        int kind;
        int fwait;
        int dwait;
    } inst_t;

    typedef struct {
        int cyc;
        int rf;
        int mdr;
        int we;
        int dsel;
    } exp_t;

    inst_t prog[$];
    exp_t  expq[$];
    inst_t cur;

    int  n_chk  = 0;
    int  n_pass = 0;
    bit  drv_en = 1'b0;
    bit  mon_en = 1'b0;
    int  tb_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference cycle count since reset release, frozen once in error.
    initial begin
        forever begin
            @(posedge clk);
            if (!reset) tb_cyc = 0;
            else if (!err) tb_cyc++;
        end
    end

    // Reference model: one instruction's externally visible profile.
    function automatic exp_t model(input inst_t in);
        exp_t e;
        bit is_mem;
        is_mem = (in.kind == 1) || (in.kind == 2) || (in.kind == 4);
        case (in.kind)
            0:       e.cyc = 4;
            2:       e.cyc = 4;
            3:       e.cyc = 3;
            default: e.cyc = 5;
        endcase
        e.cyc  = e.cyc + in.fwait + (is_mem ? in.dwait : 0);
        e.rf   = (in.kind == 0 || in.kind == 1 || in.kind == 4) ? 1 : 0;
        e.mdr  = (in.kind == 1 || in.kind == 4) ? 1 : 0;
        e.we   = (in.kind == 2) ? in.dwait + 1 : 0;
        e.dsel = is_mem ? in.dwait + 1 : 0;
        return e;
    endfunction

    task automatic issue(input int kind, input int fw, input int dw);
        inst_t in;
        in.kind  = kind;
        in.fwait = fw;
        in.dwait = dw;
        prog.push_back(in);
        expq.push_back(model(in));
    endtask

    // Memory / decode driver: responds to the handshake after the planned waits.
    initial begin : driver
        int  wcnt;
        int  tgt;
        bit  prev_req;
        bit  prev_hs;
        bit  prev_fetch;
        wcnt = 0; prev_req = 0; prev_hs = 0; prev_fetch = 0;
        forever begin
            @(negedge clk);
            if (!drv_en) begin
                wcnt = 0; prev_req = 0; prev_hs = 0; prev_fetch = 0;
            end else begin
                if (prev_hs) begin
                    wcnt = 0;
                    if (prev_fetch && prog.size() != 0) begin
                        cur      = prog.pop_front();
                        is_load  = (cur.kind == 1) || (cur.kind == 4);
                        is_store = (cur.kind == 2) || (cur.kind == 4);
                        is_ctrl  = (cur.kind == 3);
                    end
                end else if (prev_req) begin
                    wcnt++;
                end
                run = (prog.size() != 0);
                #1;
                if (mem_req) begin
                    if (mem_sel) tgt = cur.dwait;
                    else tgt = (prog.size() != 0) ? prog[0].fwait : 0;
                    mem_ready = (wcnt == tgt);
                end else begin
                    // Noise on an idle port must be ignored.
                    mem_ready = 1'($urandom_range(0, 1));
                end
                prev_req   = mem_req;
                prev_hs    = mem_req && mem_ready;
                prev_fetch = !mem_sel;
            end
        end
    end

    // Monitor: profiles each instruction from fetch start to retire.
    initial begin : monitor
        bit   in_inst;
        int   m_cyc, m_ir, m_mdr, m_rf, m_we, m_dsel, m_bad;
        exp_t e;
        in_inst = 0;
        m_cyc = 0; m_ir = 0; m_mdr = 0; m_rf = 0; m_we = 0; m_dsel = 0; m_bad = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!mon_en) begin
                in_inst = 0;
            end else begin
                if (!in_inst && mem_req && !mem_sel) begin
                    in_inst = 1;
                    m_cyc = 0; m_ir = 0; m_mdr = 0; m_rf = 0; m_we = 0; m_dsel = 0; m_bad = 0;
                end
                if (in_inst) begin
                    m_cyc++;
                    if (ir_we)              m_ir++;
                    if (mdr_we)             m_mdr++;
                    if (rf_we)              m_rf++;
                    if (mem_we)             m_we++;
                    if (mem_req && mem_sel) m_dsel++;
                    if ((pc_we !== retire) || (mem_we && !mem_sel) || err) m_bad++;
                    if (retire) begin
                        if (expq.size() == 0) begin
                            n_chk++;
                            $display("FAIL extra_retire: got retire, expected none");
                        end else begin
                            e = expq.pop_front();
                            chk("cpi",       32'(m_cyc),  32'(e.cyc));
                            chk("ir_we",     32'(m_ir),   32'd1);
                            chk("mdr_we",    32'(m_mdr),  32'(e.mdr));
                            chk("rf_we",     32'(m_rf),   32'(e.rf));
                            chk("mem_we",    32'(m_we),   32'(e.we));
                            chk("data_cyc",  32'(m_dsel), 32'(e.dsel));
                            chk("protocol",  32'(m_bad),  32'd0);
                        end
                        in_inst = 0;
                    end else if (m_cyc > 40) begin
                        n_chk++;
                        $display("FAIL inst_stuck: got %0d cycles, expected retire", m_cyc);
                        in_inst = 0;
                    end
                end
            end
        end
    end

    initial begin : main
        int  wc;
        bit  seen;
        reset     = 1'b0;
        run       = 1'b1;
        mem_ready = 1'b1;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_ctrl   = 1'b0;

        // Reset: everything quiet even with run=1 and mem_ready=1.
        #2;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_ir_we",   32'(ir_we),   32'd0);
        chk("rst_state",   32'(state),   32'd0);
        chk("rst_err",     32'(err),     32'd0);
`ifdef PERF_CNT_EN
        chk("rst_cyc_cnt",  cyc_cnt,  32'd0);
        chk("rst_inst_cnt", inst_cnt, 32'd0);
`endif

        // run=0: no request, stay in S_IF.
        @(negedge clk);
        run   = 1'b0;
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #2;
            chk("idle_mem_req", 32'(mem_req), 32'd0);
            chk("idle_state",   32'(state),   32'd0);
        end

        // Program: directed opening, then random mix with waits up to TO-1.
        issue(0, 0, 0);
        issue(1, 0, 2);
        issue(2, 0, 0);
        issue(3, 0, 0);
        issue(4, 1, 1);
        for (int i = 0; i < N_PROG; i++) begin
            issue(int'($urandom_range(0, 4)), int'($urandom_range(0, TO - 1)),
                  int'($urandom_range(0, TO - 1)));
        end
        #1;
        mon_en = 1'b1;
        drv_en = 1'b1;
        for (int c = 0; c < 3000 && expq.size() != 0; c++) @(negedge clk);
        if (expq.size() != 0) begin
            n_chk++;
            $display("FAIL prog_drain: got %0d pending, expected 0", expq.size());
        end
        repeat (3) @(negedge clk);
        drv_en    = 1'b0;
        mon_en    = 1'b0;
        run       = 1'b0;
        mem_ready = 1'b0;
        #2;
        chk("prog_end_state", 32'(state), 32'd0);
        chk("prog_end_err",   32'(err),   32'd0);
`ifdef PERF_CNT_EN
        chk("inst_cnt", inst_cnt, 32'(N_PROG + 5));
        chk("cyc_cnt",  cyc_cnt,  32'(tb_cyc));
`endif

        // Reset in the middle of a data access drops mem_req with no edge.
        @(negedge clk);
        is_load   = 1'b1;
        is_store  = 1'b0;
        is_ctrl   = 1'b0;
        run       = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        run       = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        chk("mem_state",   32'(state),   32'd3);
        chk("mem_req_hi",  32'(mem_req), 32'd1);
        chk("mem_sel_hi",  32'(mem_sel), 32'd1);
        chk("mem_we_load", 32'(mem_we),  32'd0);
        #1;
        reset = 1'b0;
        #1;
        chk("async_mem_req", 32'(mem_req), 32'd0);
        chk("async_state",   32'(state),   32'd0);
        @(negedge clk);
        reset   = 1'b1;
        is_load = 1'b0;

        // Timeout: fetch never acknowledged.
        @(negedge clk);
        run       = 1'b1;
        mem_ready = 1'b0;
        wc        = 0;
        seen      = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #2;
            if (state == 3'd5) begin
                seen = 1'b1;
                break;
            end
            if (mem_req) wc++;
            @(negedge clk);
        end
        chk("timeout_seen",  32'(seen), 32'd1);
        chk("timeout_waits", 32'(wc),   32'(TO));
        chk("timeout_err",   32'(err),  32'd1);
        mem_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #2;
            chk("err_mem_req", 32'(mem_req), 32'd0);
            chk("err_ir_we",   32'(ir_we),   32'd0);
            chk("err_state",   32'(state),   32'd5);
            chk("err_sticky",  32'(err),     32'd1);
        end
        #1;
        reset = 1'b0;
        #1;
        chk("err_cleared",   32'(err),   32'd0);
        chk("err_rst_state", 32'(state), 32'd0);
        run = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
